rf_wb_arbiter: RTL and testbench

Writeback arbiter and sequencer for the dual-write-port integer register file of the superscalar core. It accepts writeback requests from NUM_REQ execution units (ALU0, ALU1, LSU, MUL by default) and grants at most two per cycle, one per RF write port. Grants are round-robin, and writes to the same rd are kept in program (sequence) order. Port outputs are registered and drive the RF write_en/rd/wd inputs directly.

---
 rtl/core_pkg.sv | 33 +++
 rtl/rr_pick2.sv | 48 ++++
 rtl/rf_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared core types, widths and program-order age compare.
// Revision : 1.0
// ============================================================================
package core_pkg;

  localparam int CORE_RS   = 5;
  localparam int CORE_XLEN = 32;
  localparam int CORE_SEQW = 6;
  // Widest sequence tag the age compare accepts; narrower tags are zero-extended.
  localparam int SEQ_MAXW  = 16;

  typedef struct packed {
    logic                 valid;
    logic [CORE_RS-1:0]   rd;
    logic [CORE_XLEN-1:0] wd;
    logic [CORE_SEQW-1:0] seq;
  } wb_req_t;

  // a is older than b when bit (w-1) of (a-b) is set; the low w bits of the
  // difference do not depend on the zero-extension above them.
  function automatic logic seq_older(input logic [SEQ_MAXW-1:0] a,
                                     input logic [SEQ_MAXW-1:0] b,
                                     input int                  w);
    logic [SEQ_MAXW-1:0] diff;
    diff = a - b;
    return diff[w-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational round-robin picker returning the first two set
//            bits of an eligibility vector, scanning circularly from ptr_i.
// Revision : 1.0
// ============================================================================
module rr_pick2 #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt0_o,
  output logic [N-1:0]  gnt1_o,
  output logic [IW-1:0] idx0_o,
  output logic [IW-1:0] idx1_o,
  output logic          vld0_o,
  output logic          vld1_o
);

  always_comb begin
    int j;
    j      = 0;
    gnt0_o = '0;
    gnt1_o = '0;
    idx0_o = '0;
    idx1_o = '0;
    vld0_o = 1'b0;
    vld1_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (elig_i[j]) begin
        if (!vld0_o) begin
          vld0_o    = 1'b1;
          gnt0_o[j] = 1'b1;
          idx0_o    = IW'(j);
        end else if (!vld1_o) begin
          vld1_o    = 1'b1;
          gnt1_o[j] = 1'b1;
          idx1_o    = IW'(j);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Round-robin writeback arbiter for the dual-write-port register
//            file, keeping same-rd writes in program order.
// Revision : 1.0
// ============================================================================
module rf_wb_arbiter
  import core_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int RS      = CORE_RS,
  parameter int XLEN    = CORE_XLEN,
  parameter int SEQW    = CORE_SEQW,
  parameter int CNTW    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][RS-1:0]     req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_wd,
  input  logic [NUM_REQ-1:0][SEQW-1:0]   req_seq,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [1:0]                     wp_en,
  output logic [1:0][RS-1:0]             wp_rd,
  output logic [1:0][XLEN-1:0]           wp_wd,
  output logic [CNTW-1:0]                defer_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_nz;
  logic [NUM_REQ-1:0] w_zero;
  logic [NUM_REQ-1:0] w_blocked;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt0;
  logic [NUM_REQ-1:0] w_gnt1;
  logic [IW-1:0]      w_idx0;
  logic [IW-1:0]      w_idx1;
  logic               w_vld0;
  logic               w_vld1;
  logic               w_defer;

  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]        defer_cnt_q, defer_cnt_d;
  logic [1:0]             wp_en_q, wp_en_d;
  logic [1:0][RS-1:0]     wp_rd_q, wp_rd_d;
  logic [1:0][XLEN-1:0]   wp_wd_q, wp_wd_d;

  // A request waits while any other pending write to the same rd is older.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic w_blk;
    assign w_nz[i]   = req_valid[i] && (req_rd[i] != '0);
    assign w_zero[i] = req_valid[i] && (req_rd[i] == '0);

    always_comb begin
      w_blk = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((j != i) && w_nz[j] && (req_rd[j] == req_rd[i]) &&
            seq_older(SEQ_MAXW'(req_seq[j]), SEQ_MAXW'(req_seq[i]), SEQW)) begin
          w_blk = 1'b1;
        end
      end
    end

    assign w_blocked[i] = w_blk;
  end

  assign w_elig = w_nz & ~w_blocked;

  rr_pick2 #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .elig_i (w_elig),
    .ptr_i  (rr_ptr_q),
    .gnt0_o (w_gnt0),
    .gnt1_o (w_gnt1),
    .idx0_o (w_idx0),
    .idx1_o (w_idx1),
    .vld0_o (w_vld0),
    .vld1_o (w_vld1)
  );

  always_comb begin
    req_ready = '0;
    if (rst) begin
      req_ready = w_zero | w_gnt0 | w_gnt1;
    end
  end

  assign w_defer = |(w_nz & ~req_ready);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_vld1) begin
      rr_ptr_d = (w_idx1 == IW'(NUM_REQ - 1)) ? '0 : w_idx1 + IW'(1);
    end else if (w_vld0) begin
      rr_ptr_d = (w_idx0 == IW'(NUM_REQ - 1)) ? '0 : w_idx0 + IW'(1);
    end
  end

  always_comb begin
    defer_cnt_d = defer_cnt_q;
    if (w_defer && (defer_cnt_q != '1)) begin
      defer_cnt_d = defer_cnt_q + CNTW'(1);
    end
  end

  // Idle ports drop enable but keep rd/wd to avoid needless toggling.
  always_comb begin
    wp_en_d = {w_vld1, w_vld0};
    wp_rd_d = wp_rd_q;
    wp_wd_d = wp_wd_q;
    if (w_vld0) begin
      wp_rd_d[0] = req_rd[w_idx0];
      wp_wd_d[0] = req_wd[w_idx0];
    end
    if (w_vld1) begin
      wp_rd_d[1] = req_rd[w_idx1];
      wp_wd_d[1] = req_wd[w_idx1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      defer_cnt_q <= '0;
      wp_en_q     <= '0;
      wp_rd_q     <= '0;
      wp_wd_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      defer_cnt_q <= defer_cnt_d;
      wp_en_q     <= wp_en_d;
      wp_rd_q     <= wp_rd_d;
      wp_wd_q     <= wp_wd_d;
    end
  end

  assign wp_en     = wp_en_q;
  assign wp_rd     = wp_rd_q;
  assign wp_wd     = wp_wd_q;
  assign defer_cnt = defer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed self-checking bench for rf_wb_arbiter.
// Revision : 1.0
// ============================================================================
module tb_rf_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]        req_valid;
  logic [3:0][4:0]   req_rd;
  logic [3:0][31:0]  req_wd;
  logic [3:0][5:0]   req_seq;

  logic [3:0]        req_ready,  s_req_ready;
  logic [1:0]        wp_en,      s_wp_en;
  logic [1:0][4:0]   wp_rd,      s_wp_rd;
  logic [1:0][31:0]  wp_wd,      s_wp_wd;
  logic [15:0]       defer_cnt;
  logic [3:0]        s_defer_cnt;

  int n_vec = 0;
  int n_err = 0;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_wd    (req_wd),
    .req_seq   (req_seq),
    .req_ready (req_ready),
    .wp_en     (wp_en),
    .wp_rd     (wp_rd),
    .wp_wd     (wp_wd),
    .defer_cnt (defer_cnt)
  );

  rf_wb_arbiter #(.CNTW(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_wd    (req_wd),
    .req_seq   (req_seq),
    .req_ready (s_req_ready),
    .wp_en     (s_wp_en),
    .wp_rd     (s_wp_rd),
    .wp_wd     (s_wp_wd),
    .defer_cnt (s_defer_cnt)
  );

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [5:0] seq);
    req_valid[i] = 1'b1;
    req_rd[i]    = rd;
    req_wd[i]    = wd;
    req_seq[i]   = seq;
  endtask

  task automatic clr_all;
    req_valid = '0;
    req_rd    = '0;
    req_wd    = '0;
    req_seq   = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr_all();
    req_valid[0] = 1'b1;
    #2;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_vec++; if (wp_en !== 2'b00) begin n_err++; $display("FAIL rst_wp_en: got %b want 00", wp_en); end
    n_vec++; if (wp_rd !== 10'd0) begin n_err++; $display("FAIL rst_wp_rd: got %h want 0", wp_rd); end
    n_vec++; if (defer_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", defer_cnt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rel_x0_ready: got %b want 0001", req_ready); end
    clr_all();
    step();
    n_vec++; if (wp_en !== 2'b00) begin n_err++; $display("FAIL rel_wp_en: got %b want 00", wp_en); end
    n_vec++; if (defer_cnt !== 16'd0) begin n_err++; $display("FAIL rel_cnt: got %0d want 0", defer_cnt); end
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA0 + 32'(i), 6'(i));
    #1;
    n_vec++; if (req_ready !== 4'b0011) begin n_err++; $display("FAIL rr_c0_ready: got %b want 0011", req_ready); end
    step();
    n_vec++; if (wp_en !== 2'b11) begin n_err++; $display("FAIL rr_c0_en: got %b want 11", wp_en); end
    n_vec++; if (wp_rd[0] !== 5'd1 || wp_rd[1] !== 5'd2) begin n_err++; $display("FAIL rr_c0_rd: got %0d,%0d want 1,2", wp_rd[0], wp_rd[1]); end
    n_vec++; if (wp_wd[0] !== 32'hA0) begin n_err++; $display("FAIL rr_c0_wd: got %h want a0", wp_wd[0]); end
    n_vec++; if (defer_cnt !== 16'd1) begin n_err++; $display("FAIL rr_c0_cnt: got %0d want 1", defer_cnt); end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b1100) begin n_err++; $display("FAIL rr_c1_ready: got %b want 1100", req_ready); end
    step();
    n_vec++; if (wp_rd[0] !== 5'd3 || wp_rd[1] !== 5'd4) begin n_err++; $display("FAIL rr_c1_rd: got %0d,%0d want 3,4", wp_rd[0], wp_rd[1]); end
    n_vec++; if (wp_wd[1] !== 32'hA3) begin n_err++; $display("FAIL rr_c1_wd: got %h want a3", wp_wd[1]); end
    n_vec++; if (defer_cnt !== 16'd1) begin n_err++; $display("FAIL rr_c1_cnt: got %0d want 1", defer_cnt); end
    clr_all();
  endtask

  task automatic test_same_rd;
    set_req(0, 5'd5, 32'hD0, 6'd10);
    set_req(1, 5'd7, 32'hD1, 6'd11);
    set_req(2, 5'd5, 32'hD2, 6'd9);
    #1;
    n_vec++; if (req_ready !== 4'b0110) begin n_err++; $display("FAIL ord_c0_ready: got %b want 0110", req_ready); end
    step();
    n_vec++; if (wp_en !== 2'b11) begin n_err++; $display("FAIL ord_c0_en: got %b want 11", wp_en); end
    n_vec++; if (wp_rd[0] !== 5'd7 || wp_rd[1] !== 5'd5) begin n_err++; $display("FAIL ord_c0_rd: got %0d,%0d want 7,5", wp_rd[0], wp_rd[1]); end
    n_vec++; if (wp_wd[1] !== 32'hD2) begin n_err++; $display("FAIL ord_c0_wd: got %h want d2", wp_wd[1]); end
    n_vec++; if (defer_cnt !== 16'd2) begin n_err++; $display("FAIL ord_c0_cnt: got %0d want 2", defer_cnt); end
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ord_c1_ready: got %b want 0001", req_ready); end
    step();
    n_vec++; if (wp_en !== 2'b01 || wp_rd[0] !== 5'd5) begin n_err++; $display("FAIL ord_c1_port: got en=%b rd=%0d want en=01 rd=5", wp_en, wp_rd[0]); end
    n_vec++; if (wp_wd[0] !== 32'hD0) begin n_err++; $display("FAIL ord_c1_wd: got %h want d0", wp_wd[0]); end
    clr_all();
  endtask

  task automatic test_seq_wrap;
    set_req(0, 5'd3, 32'hE0, 6'd2);
    set_req(1, 5'd3, 32'hE1, 6'd62);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_c0_ready: got %b want 0010", req_ready); end
    step();
    n_vec++; if (wp_en !== 2'b01 || wp_wd[0] !== 32'hE1) begin n_err++; $display("FAIL wrap_c0_port: got en=%b wd=%h want en=01 wd=e1", wp_en, wp_wd[0]); end
    n_vec++; if (defer_cnt !== 16'd3) begin n_err++; $display("FAIL wrap_c0_cnt: got %0d want 3", defer_cnt); end
    req_valid[1] = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_c1_ready: got %b want 0001", req_ready); end
    step();
    n_vec++; if (wp_en !== 2'b01 || wp_wd[0] !== 32'hE0) begin n_err++; $display("FAIL wrap_c1_port: got en=%b wd=%h want en=01 wd=e0", wp_en, wp_wd[0]); end
    clr_all();
  endtask

  task automatic test_x0;
    set_req(0, 5'd0, 32'hF0, 6'd20);
    set_req(1, 5'd0, 32'hF1, 6'd21);
    set_req(2, 5'd8, 32'hF2, 6'd22);
    set_req(3, 5'd9, 32'hF3, 6'd23);
    #1;
    n_vec++; if (req_ready !== 4'b1111) begin n_err++; $display("FAIL x0_ready: got %b want 1111", req_ready); end
    step();
    n_vec++; if (wp_en !== 2'b11) begin n_err++; $display("FAIL x0_en: got %b want 11", wp_en); end
    n_vec++; if (wp_rd[0] !== 5'd8 || wp_rd[1] !== 5'd9) begin n_err++; $display("FAIL x0_rd: got %0d,%0d want 8,9", wp_rd[0], wp_rd[1]); end
    n_vec++; if (defer_cnt !== 16'd3) begin n_err++; $display("FAIL x0_cnt: got %0d want 3", defer_cnt); end
    clr_all();
  endtask

  task automatic test_saturation;
    set_req(0, 5'd6, 32'h60, 6'd20);
    set_req(1, 5'd6, 32'h61, 6'd21);
    set_req(2, 5'd6, 32'h62, 6'd22);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sat_ready: got %b want 0001", req_ready); end
    for (int c = 0; c < 10; c++) step();
    n_vec++; if (s_defer_cnt !== 4'd13) begin n_err++; $display("FAIL sat_mid_cnt: got %0d want 13", s_defer_cnt); end
    n_vec++; if (wp_en !== 2'b01 || wp_rd[0] !== 5'd6) begin n_err++; $display("FAIL sat_port: got en=%b rd=%0d want en=01 rd=6", wp_en, wp_rd[0]); end
    for (int c = 0; c < 10; c++) step();
    n_vec++; if (s_defer_cnt !== 4'd15) begin n_err++; $display("FAIL sat_end_cnt: got %0d want 15", s_defer_cnt); end
    n_vec++; if (defer_cnt !== 16'd23) begin n_err++; $display("FAIL sat_wide_cnt: got %0d want 23", defer_cnt); end
    clr_all();
    step();
    n_vec++; if (s_defer_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold_cnt: got %0d want 15", s_defer_cnt); end
  endtask

  task automatic test_async_reset;
    set_req(2, 5'd12, 32'h55, 6'd30);
    step();
    n_vec++; if (wp_en !== 2'b01) begin n_err++; $display("FAIL arst_pre_en: got %b want 01", wp_en); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (wp_en !== 2'b00 || wp_rd[0] !== 5'd0) begin n_err++; $display("FAIL arst_clear: got en=%b rd=%0d want en=00 rd=0", wp_en, wp_rd[0]); end
    n_vec++; if (defer_cnt !== 16'd0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", defer_cnt); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL arst_ready: got %b want 0000", req_ready); end
    clr_all();
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 5'd1, 32'h71, 6'd1);
    set_req(3, 5'd3, 32'h73, 6'd2);
    #1;
    n_vec++; if (req_ready !== 4'b1010) begin n_err++; $display("FAIL arst_rel_ready: got %b want 1010", req_ready); end
    step();
    n_vec++; if (wp_rd[0] !== 5'd1 || wp_rd[1] !== 5'd3) begin n_err++; $display("FAIL arst_ptr: got %0d,%0d want 1,3", wp_rd[0], wp_rd[1]); end
    clr_all();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_same_rd();
    test_seq_wrap();
    test_x0();
    test_saturation();
    test_async_reset();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
